// File: rtl/kb_event_scanner.sv
`default_nettype none
// ============================================================================
// Module   : kb_event_scanner
// Brief    : Diffs successive 126-key bitmap reports into make/break/repeat events
// Revision : 1.0 - initial release
// ============================================================================
module kb_event_scanner #(
    parameter int TYPEMATIC_EN = 1,
    parameter int BREAK_FIRST  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [125:0] fifo_dout,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [6:0]   evt_key,
    output logic         evt_make,
    output logic         evt_repeat,
    output logic         busy
);

    localparam logic [6:0] c_LAST_IDX = 7'd125;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LATCH  = 3'd2,
        S_SCAN   = 3'd3,
        S_EMIT   = 3'd4,
        S_REPEAT = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [125:0]   r_held;
    logic [125:0]   r_new_rep;
    logic [6:0]     r_idx;
    logic           r_make_pass;
    logic           r_emitted;
    logic [6:0]     r_last_key;
    logic           r_last_vld;
    logic [6:0]     r_evt_key;
    logic           r_evt_make;

    logic           w_held_bit;
    logic           w_new_bit;
    logic           w_qual;
    logic           w_at_last;
    logic           w_to_make;
    logic           w_report_end;
    logic           w_repeat_ok;
    logic           w_load_rep;
    logic           w_hit;
    logic           w_step;
    logic           w_emit_ack;
    logic           w_enter_repeat;

    assign w_held_bit   = r_held[r_idx];
    assign w_new_bit    = r_new_rep[r_idx];
    assign w_at_last    = (r_idx == c_LAST_IDX);
    assign w_to_make    = w_at_last && (BREAK_FIRST != 0) && !r_make_pass;
    assign w_report_end = w_at_last && !w_to_make;
    assign w_repeat_ok  = !r_emitted && (TYPEMATIC_EN != 0) && (|r_new_rep)
                          && r_last_vld && r_held[r_last_key];

    // Qualifying difference for the current pass
    always_comb begin
        w_qual = 1'b0;
        if (BREAK_FIRST == 0) begin
            w_qual = w_held_bit ^ w_new_bit;
        end else if (r_make_pass) begin
            w_qual = ~w_held_bit & w_new_bit;
        end else begin
            w_qual = w_held_bit & ~w_new_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_load_rep     = 1'b0;
        w_hit          = 1'b0;
        w_step         = 1'b0;
        w_emit_ack     = 1'b0;
        w_enter_repeat = 1'b0;
        fifo_rd_en     = 1'b0;
        evt_valid      = 1'b0;
        evt_repeat     = 1'b0;
        busy           = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_next = S_POP;
                end
            end
            S_POP: begin
                fifo_rd_en = 1'b1;
                w_next     = S_LATCH;
            end
            S_LATCH: begin
                w_load_rep = 1'b1;
                w_next     = S_SCAN;
            end
            S_SCAN: begin
                if (w_qual) begin
                    w_hit  = 1'b1;
                    w_next = S_EMIT;
                end else begin
                    w_step = 1'b1;
                    if (w_report_end) begin
                        if (w_repeat_ok) begin
                            w_enter_repeat = 1'b1;
                            w_next         = S_REPEAT;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
            end
            S_EMIT: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    w_emit_ack = 1'b1;
                    w_step     = 1'b1;
                    // An event was emitted, so a report ending here never repeats
                    w_next     = w_report_end ? S_IDLE : S_SCAN;
                end
            end
            S_REPEAT: begin
                evt_valid  = 1'b1;
                evt_repeat = 1'b1;
                if (evt_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign evt_key  = r_evt_key;
    assign evt_make = r_evt_make;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held      <= '0;
            r_new_rep   <= '0;
            r_idx       <= '0;
            r_make_pass <= 1'b0;
            r_emitted   <= 1'b0;
            r_last_key  <= '0;
            r_last_vld  <= 1'b0;
            r_evt_key   <= '0;
            r_evt_make  <= 1'b0;
        end else begin
            if (w_load_rep) begin
                r_new_rep   <= fifo_dout;
                r_idx       <= '0;
                r_make_pass <= 1'b0;
                r_emitted   <= 1'b0;
            end
            if (w_hit) begin
                r_evt_key  <= r_idx;
                r_evt_make <= w_new_bit;
            end
            if (w_enter_repeat) begin
                r_evt_key  <= r_last_key;
                r_evt_make <= 1'b1;
            end
            if (w_emit_ack) begin
                r_held[r_idx] <= w_new_bit;
                r_emitted     <= 1'b1;
                if (w_new_bit) begin
                    r_last_key <= r_idx;
                    r_last_vld <= 1'b1;
                end else if (r_idx == r_last_key) begin
                    r_last_vld <= 1'b0;
                end
            end
            if (w_step) begin
                if (w_to_make) begin
                    r_make_pass <= 1'b1;
                    r_idx       <= '0;
                end else if (!w_at_last) begin
                    r_idx <= r_idx + 7'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kb_event_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_kb_event_scanner
// Brief    : Self-checking bench; three parameterisations against a report model
// Revision : 1.0 - initial release
// ============================================================================
module tb_kb_event_scanner;

    localparam int c_NDUT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         evt_ready;
    logic [125:0] r_rep;
    int           r_req_cnt = 0;
    int           r_rp = 0;
    int           checks = 0;
    int           errors = 0;

    logic         w_fe   [c_NDUT];
    logic         w_rd   [c_NDUT];
    logic [125:0] r_fd   [c_NDUT];
    logic         w_vld  [c_NDUT];
    logic [6:0]   w_key  [c_NDUT];
    logic         w_make [c_NDUT];
    logic         w_rpt  [c_NDUT];
    logic         w_busy [c_NDUT];
    int           r_pop  [c_NDUT] = '{default: 0};

    // Observed events: {dut[1:0], key[6:0], make, repeat}
    logic [10:0]  evq [$];
    logic [8:0]   exp_q [$];

    bit [125:0]   m_held [c_NDUT];
    int           m_last [c_NDUT];
    bit           m_lv   [c_NDUT];

    always #5 clk = ~clk;

    // dut0: defaults, dut1: combined pass, dut2: no typematic repeat
    kb_event_scanner #(.TYPEMATIC_EN(1), .BREAK_FIRST(1)) u_dut0 (
        .clk(clk), .reset(reset), .fifo_empty(w_fe[0]), .fifo_rd_en(w_rd[0]),
        .fifo_dout(r_fd[0]), .evt_valid(w_vld[0]), .evt_ready(evt_ready),
        .evt_key(w_key[0]), .evt_make(w_make[0]), .evt_repeat(w_rpt[0]), .busy(w_busy[0]));
    kb_event_scanner #(.TYPEMATIC_EN(1), .BREAK_FIRST(0)) u_dut1 (
        .clk(clk), .reset(reset), .fifo_empty(w_fe[1]), .fifo_rd_en(w_rd[1]),
        .fifo_dout(r_fd[1]), .evt_valid(w_vld[1]), .evt_ready(evt_ready),
        .evt_key(w_key[1]), .evt_make(w_make[1]), .evt_repeat(w_rpt[1]), .busy(w_busy[1]));
    kb_event_scanner #(.TYPEMATIC_EN(0), .BREAK_FIRST(1)) u_dut2 (
        .clk(clk), .reset(reset), .fifo_empty(w_fe[2]), .fifo_rd_en(w_rd[2]),
        .fifo_dout(r_fd[2]), .evt_valid(w_vld[2]), .evt_ready(evt_ready),
        .evt_key(w_key[2]), .evt_make(w_make[2]), .evt_repeat(w_rpt[2]), .busy(w_busy[2]));

    // One-entry upstream FIFO per DUT, refilled by each requested report
    always @(posedge clk) begin
        for (int k = 0; k < c_NDUT; k++) begin
            if (w_rd[k]) begin
                r_pop[k] <= r_pop[k] + 1;
                r_fd[k]  <= r_rep;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < c_NDUT; k++) begin
            w_fe[k] = (r_pop[k] == r_req_cnt);
        end
    end

    always @(posedge clk) begin
        if (!reset && evt_ready) begin
            for (int k = 0; k < c_NDUT; k++) begin
                if (w_vld[k]) begin
                    evq.push_back({2'(k), w_key[k], w_make[k], w_rpt[k]});
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < c_NDUT; k++) begin
            m_held[k] = '0;
            m_last[k] = 0;
            m_lv[k]   = 1'b0;
        end
    endtask

    // Expected event list for one report: set differences, breaks then makes
    // (or index order), followed by a repeat when nothing changed.
    task automatic model_report(input int k, input logic [125:0] r);
        bit bf;
        bit te;
        bf = (k != 1);
        te = (k != 2);
        exp_q = {};
        if (bf) begin
            for (int i = 0; i < 126; i++)
                if (m_held[k][i] && !r[i]) exp_q.push_back({7'(i), 1'b0, 1'b0});
            for (int i = 0; i < 126; i++)
                if (!m_held[k][i] && r[i]) exp_q.push_back({7'(i), 1'b1, 1'b0});
        end else begin
            for (int i = 0; i < 126; i++)
                if (m_held[k][i] != r[i]) exp_q.push_back({7'(i), r[i], 1'b0});
        end
        foreach (exp_q[j]) begin
            if (exp_q[j][1]) begin
                m_last[k] = int'(exp_q[j][8:2]);
                m_lv[k]   = 1'b1;
            end else if (int'(exp_q[j][8:2]) == m_last[k]) begin
                m_lv[k] = 1'b0;
            end
        end
        m_held[k] = r;
        if (exp_q.size() == 0 && te && r != '0 && m_lv[k] && m_held[k][m_last[k]])
            exp_q.push_back({7'(m_last[k]), 1'b1, 1'b1});
    endtask

    task automatic start_report(input logic [125:0] r);
        @(negedge clk);
        r_rep     = r;
        r_req_cnt = r_req_cnt + 1;
    endtask

    task automatic finish_report(input bit rand_rdy);
        int         cyc;
        bit         done;
        logic [8:0] got [$];
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            evt_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            done = 1'b1;
            for (int k = 0; k < c_NDUT; k++)
                if (!w_fe[k] || w_busy[k]) done = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL report_timeout: still busy after %0d cycles, required idle", cyc);
        end
        for (int k = 0; k < c_NDUT; k++) begin
            got = {};
            for (int j = r_rp; j < evq.size(); j++)
                if (int'(evq[j][10:9]) == k) got.push_back(evq[j][8:0]);
            model_report(k, r_rep);
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL event_count dut%0d: got %0d events, required %0d", k, got.size(), exp_q.size());
            end
            for (int j = 0; j < got.size() && j < exp_q.size(); j++) begin
                checks++;
                if (got[j] !== exp_q[j]) begin
                    errors++;
                    $display("FAIL event dut%0d #%0d: got key=%0d make=%0d rpt=%0d, required key=%0d make=%0d rpt=%0d",
                             k, j, got[j][8:2], got[j][1], got[j][0], exp_q[j][8:2], exp_q[j][1], exp_q[j][0]);
                end
            end
            checks++;
            if (r_pop[k] != r_req_cnt) begin
                errors++;
                $display("FAIL pop_count dut%0d: got %0d pops, required %0d", k, r_pop[k], r_req_cnt);
            end
        end
        r_rp = evq.size();
    endtask

    task automatic apply_report(input logic [125:0] r, input bit rand_rdy);
        start_report(r);
        finish_report(rand_rdy);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        evt_ready = 1'b0;
        r_rep     = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_NDUT; k++) begin
            checks++;
            if ({w_rd[k], w_vld[k], w_key[k], w_make[k], w_rpt[k], w_busy[k]} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got rd=%b vld=%b key=%0d make=%b rpt=%b busy=%b, required all 0",
                         k, w_rd[k], w_vld[k], w_key[k], w_make[k], w_rpt[k], w_busy[k]);
            end
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_press();
        logic [125:0] r;
        r = '0; r[4] = 1'b1;
        apply_report(r, 1'b0);
    endtask

    task automatic test_rollover();
        logic [125:0] r;
        r = '0; r[5] = 1'b1;
        apply_report(r, 1'b0);
    endtask

    task automatic test_repeat();
        logic [125:0] r;
        r = '0; r[4] = 1'b1;
        apply_report(r, 1'b0);
        r[9] = 1'b1;
        apply_report(r, 1'b0);
        apply_report(r, 1'b1);
    endtask

    task automatic test_release_all();
        logic [125:0] r;
        r = '0; r[0] = 1'b1; r[63] = 1'b1; r[125] = 1'b1;
        apply_report(r, 1'b0);
        apply_report('0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [125:0] r;
        int           cyc;
        int           pops;
        r = '0; r[125] = 1'b1;
        evt_ready = 1'b0;
        start_report(r);
        cyc = 0;
        while (!w_vld[0] && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        pops = r_pop[0];
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (!w_vld[0] || w_key[0] !== 7'd125 || w_make[0] !== 1'b1 || w_rpt[0] !== 1'b0 || w_rd[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got vld=%b key=%0d make=%b rpt=%b rd=%b, required 1/125/1/0/0",
                         c, w_vld[0], w_key[0], w_make[0], w_rpt[0], w_rd[0]);
            end
            @(negedge clk);
        end
        checks++;
        if (r_pop[0] != pops) begin
            errors++;
            $display("FAIL stall_no_pop: got %0d pops, required %0d", r_pop[0], pops);
        end
        finish_report(1'b0);
    endtask

    task automatic test_reset_during_emit();
        logic [125:0] r;
        int           cyc;
        r = '0; r[20] = 1'b1;
        evt_ready = 1'b0;
        start_report(r);
        cyc = 0;
        while (!w_vld[0] && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!w_vld[0]) begin
            errors++;
            $display("FAIL reach_emit: got vld=0 after %0d cycles, required 1", cyc);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < c_NDUT; k++) begin
            checks++;
            if (w_vld[k] !== 1'b0 || w_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_drop dut%0d: got vld=%b busy=%b, required 0/0", k, w_vld[k], w_busy[k]);
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        r_rp = evq.size();
        r = '0; r[7] = 1'b1;
        apply_report(r, 1'b0);
    endtask

    task automatic test_random();
        logic [125:0] r;
        for (int n = 0; n < 30; n++) begin
            r = m_held[0];
            case ($urandom_range(0, 5))
                0: r = '0;
                1: begin
                    if (r == '0) r[$urandom_range(0, 125)] = 1'b1;
                end
                default: begin
                    for (int i = 0; i < 126; i++)
                        if ($urandom_range(0, 29) == 0) r[i] = ~r[i];
                end
            endcase
            apply_report(r, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_rollover();
        test_repeat();
        test_release_all();
        test_backpressure();
        test_reset_during_emit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kb_event_scanner.md
KB_EVENT_SCANNER -- requirements
Module: kb_event_scanner

Interface
REQ-001 SHALL have parameter TYPEMATIC_EN, default 1, meaning a repeat report re-emits the make event of the last pressed key.
REQ-002 SHALL have parameter BREAK_FIRST, default 1, meaning break events are emitted before make events within one report.
REQ-003 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port fifo_empty, input, 1 bit, upstream key-report FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en, output, 1 bit, single-cycle pop request to the upstream FIFO.
REQ-007 SHALL have port fifo_dout, input, 126 bits, key bitmap; bit i=1 means key index i is pressed; valid the cycle after fifo_rd_en.
REQ-008 SHALL have port evt_valid, output, 1 bit, key event available.
REQ-009 SHALL have port evt_ready, input, 1 bit, consumer accepts the event.
REQ-010 SHALL have port evt_key, output, 7 bits, key index 0..125.
REQ-011 SHALL have port evt_make, output, 1 bit, 1 = press (make), 0 = release (break).
REQ-012 SHALL have port evt_repeat, output, 1 bit, event is a typematic repeat.
REQ-013 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, POP, LATCH, SCAN, EMIT, REPEAT.
REQ-015 SHALL go IDLE->POP when fifo_empty=0, and SHALL assert fifo_rd_en for exactly one cycle in POP.
REQ-016 SHALL go POP->LATCH unconditionally, and SHALL capture fifo_dout into register new_rep in LATCH.
REQ-017 In LATCH, SHALL set idx=0 and pass=0 (break pass) when BREAK_FIRST=1, or set a single combined pass when BREAK_FIRST=0; then go to SCAN.
REQ-018 SCAN SHALL examine one index per cycle: break pass qualifies held[idx]=1 & new_rep[idx]=0; make pass qualifies held[idx]=0 & new_rep[idx]=1; combined pass qualifies any difference.
REQ-019 On a qualifying bit, SHALL go to EMIT with evt_key=idx and evt_make=new_rep[idx]; otherwise SHALL increment idx.
REQ-020 When idx=125 with no qualifying bit: if in break pass, SHALL go to make pass with idx=0; otherwise SHALL end the report.
REQ-021 evt_valid SHALL be high only in EMIT/REPEAT; evt_key, evt_make and evt_repeat SHALL stay stable until the cycle evt_valid&evt_ready.
REQ-022 On an EMIT handshake, SHALL set held[idx] to new_rep[idx]; if make, SHALL set last_key=idx and last_vld=1; if break of last_key, SHALL clear last_vld; then SHALL continue SCAN at idx+1, or apply the REQ-020 rule at idx=125.
REQ-023 End of report: if zero events were emitted, TYPEMATIC_EN=1, new_rep!=0, last_vld=1 and held[last_key]=1, SHALL go to REPEAT; otherwise SHALL go to IDLE.
REQ-024 REPEAT SHALL present evt_key=last_key, evt_make=1, evt_repeat=1, and SHALL go to IDLE on handshake; evt_repeat SHALL be 0 in EMIT.
REQ-025 SHALL never pop the FIFO outside IDLE->POP; no new report is read while events are pending.
REQ-026 An all-zero report SHALL produce breaks for every held key and no repeat.
REQ-027 Worst-case report latency without backpressure SHALL be 3 + 2*126 cycles plus one cycle per event (BREAK_FIRST=1).

Reset
REQ-028 On reset, SHALL force state=IDLE, held=0, new_rep=0, idx=0, last_vld=0, last_key=0.
REQ-029 During reset, outputs SHALL be fifo_rd_en=0, evt_valid=0, evt_key=0, evt_make=0, evt_repeat=0, busy=0.
REQ-030 Reset asserted mid-EMIT SHALL drop the pending event immediately, and no partial event SHALL be emitted after release.

Verification
REQ-031 Single press: report bit 4 set, evt_ready=1 -> one event {key=4, make=1, repeat=0}, then IDLE, held=bit 4.
REQ-032 Roll-over: held={4}, new report={5} -> break 4 precedes make 5 (BREAK_FIRST=1); with BREAK_FIRST=0 the order is 4 break, 5 make by index.
REQ-033 Repeat: held={4,9} with last pressed key 9, identical report arrives -> one event {key=9, make=1, repeat=1}; with TYPEMATIC_EN=0 -> no event.
REQ-034 Backpressure: evt_ready=0 for 10 cycles on a make of key 125 -> event held stable, no fifo_rd_en, and key 125 emitted once when ready rises.
REQ-035 Release all: held={0,63,125}, report=0 -> breaks for 0, 63, 125 in order, last_vld=0, no repeat.
REQ-036 Reset during EMIT, then report {7} -> evt_valid drops asynchronously, and after release only {key=7, make=1} is emitted.
